seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for the 8-digit common-anode seven-segment display.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment patterns
// in {CA,CB,CC,CD,CE,CF,CG} order and the digit-index width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // A single-digit display still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with tear-free valid/ready loading.
// Define SEG7_DP_EN to add the per-digit decimal point (load_dp in, DP out).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    CLK100MHZ,
    input  logic                    BTNC,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic                    DP,
`endif
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic                    pending_q, pending_d;
    logic                    ready_q, ready_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic                    presc_term;
    logic                    frame_end;
    logic                    transfer;
    logic                    load_commit;
    logic [3:0]              cur_nibble;
    logic                    cur_en;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [6:0]              dec_seg;

    assign presc_term  = (presc_q == PS_LAST);
    assign frame_end   = presc_term && (index_q == IDX_LAST);
    assign transfer    = load_valid && ready_q;
    // Only a word that was already pending before the boundary cycle is committed.
    assign load_commit = frame_end && pending_q;
    assign cur_nibble  = display_q[{index_q, 2'b00} +: 4];
    assign cur_en      = digit_en[index_q];
    assign sel_onehot  = NUM_DIGITS'(1) << index_q;

    hex_to_seg7 u_dec (
        .hex (cur_nibble),
        .seg (dec_seg)
    );

    always_comb begin
        presc_d   = presc_q + 1'b1;
        index_d   = index_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (presc_term) begin
            presc_d = '0;
            index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end
        if (load_commit) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (transfer) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end
        ready_d = ~pending_d;
        an_d    = ~(sel_onehot & digit_en);
        seg_d   = cur_en ? dec_seg : SEG_BLANK;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            presc_q   <= '0;
            index_q   <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            presc_q   <= presc_d;
            index_q   <= index_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
    logic [NUM_DIGITS-1:0] dp_disp_q, dp_disp_d;
    logic                  dp_q, dp_d;

    // Decimal points follow exactly the same shadow/commit path as the nibbles.
    always_comb begin
        dp_shadow_d = dp_shadow_q;
        dp_disp_d   = dp_disp_q;
        if (load_commit) begin
            dp_disp_d = dp_shadow_q;
        end else if (transfer) begin
            dp_shadow_d = load_dp;
        end
        dp_d = ~(dp_disp_q[index_q] & cur_en);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            dp_shadow_q <= '0;
            dp_disp_q   <= '0;
            dp_q        <= 1'b1;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_disp_q   <= dp_disp_d;
            dp_q        <= dp_d;
        end
    end

    assign DP = dp_q;
`endif

    assign load_ready = ready_q;
    assign AN         = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard testbench for seg7_scan_driver (REFRESH_DIV=4, 8 digits, 32-cycle frame).
// Define SEG7_DP_EN for both bench and RTL to exercise the decimal-point path.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       ready;
      logic       dp;
   } exp_t;

   logic        clk = 1'b0;
   logic        BTNC;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic [7:0]  digit_en;
   logic [7:0]  load_dp;
   logic        CA, CB, CC, CD, CE, CF, CG;
   logic [7:0]  AN;
   logic        DP;
   logic [6:0]  seg_out;

   int tests_run = 0;
   int tests_failed = 0;
   int t_model = 0;
   bit m_valid = 0;
   exp_t exp_q[$];

   logic [6:0] seg_table [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   always #5 clk = ~clk;

   assign seg_out = {CA, CB, CC, CD, CE, CF, CG};

   seg7_scan_driver #(
      .NUM_DIGITS  (8),
      .REFRESH_DIV (4)
   ) dut (
      .CLK100MHZ  (clk),
      .BTNC       (BTNC),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .digit_en   (digit_en),
`ifdef SEG7_DP_EN
      .load_dp    (load_dp),
      .DP         (DP),
`endif
      .CA         (CA),
      .CB         (CB),
      .CC         (CC),
      .CD         (CD),
      .CE         (CE),
      .CF         (CF),
      .CG         (CG),
      .AN         (AN)
   );

`ifndef SEG7_DP_EN
   assign DP = 1'b1;
`endif

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: at each edge, predict the registered outputs that edge produces.
   initial begin
      exp_t e;
      int idx;
      logic [3:0] nib;
      logic [31:0] m_disp, m_shadow;
      logic [7:0] m_disp_dp, m_shadow_dp;
      bit m_pend;
      m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 0;
      forever begin
         @(posedge clk);
         if (BTNC) begin
            t_model = 0;
            m_pend = 0;
            m_disp = '0;
            m_shadow = '0;
            m_disp_dp = '0;
            m_shadow_dp = '0;
            e = '{an: 8'hFF, seg: 7'h7F, ready: 1'b1, dp: 1'b1};
            m_valid = 1;
         end else if (m_valid) begin
            idx = (t_model / 4) % 8;
            nib = m_disp[idx*4 +: 4];
            e.an = ~((8'd1 << idx) & digit_en);
            e.seg = digit_en[idx] ? seg_table[nib] : 7'h7F;
            e.dp = ~(m_disp_dp[idx] & digit_en[idx]);
            if ((t_model % 32 == 31) && m_pend) begin
               m_disp = m_shadow;
               m_disp_dp = m_shadow_dp;
               m_pend = 0;
            end else if (load_valid && !m_pend) begin
               m_shadow = load_data;
               m_shadow_dp = load_dp;
               m_pend = 1;
            end
            e.ready = !m_pend;
            t_model++;
         end
         if (m_valid) exp_q.push_back(e);
      end
   end

   // Scoreboard: compare every predicted cycle shortly after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_an", 32'(AN), 32'(e.an));
            checkOutput("sb_seg", 32'(seg_out), 32'(e.seg));
            checkOutput("sb_ready", 32'(load_ready), 32'(e.ready));
`ifdef SEG7_DP_EN
            checkOutput("sb_dp", 32'(DP), 32'(e.dp));
`endif
         end
      end
   end

   // Offers a word and holds it until the DUT accepts it; returns the accepting edge.
   task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dp, output int acc_t);
      bit done;
      done = 0;
      acc_t = -1;
      @(negedge clk);
      load_data = data;
      load_dp = dp;
      load_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (load_ready) begin
            @(posedge clk);
            #1;
            done = 1;
            acc_t = t_model - 1;
            load_valid = 1'b0;
            checkOutput("ready_drop", 32'(load_ready), 32'd0);
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         load_valid = 1'b0;
         checkOutput("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic waitUntil(input int target);
      for (int i = 0; i < 500 && t_model < target; i++) begin
         @(posedge clk);
         #1;
      end
      if (t_model < target) checkOutput("wait_timeout", 32'(t_model), 32'(target));
   endtask

   initial begin
      #100000;
      checkOutput("watchdog", 32'd0, 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      int acc1, acc2;
      BTNC = 1'b1;
      load_valid = 1'b0;
      load_data = '0;
      load_dp = '0;
      digit_en = '0;

      // Reset held for two edges
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_an", 32'(AN), 32'hFF);
      checkOutput("rst_seg", 32'(seg_out), 32'h7F);
      checkOutput("rst_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      BTNC = 1'b0;
      digit_en = 8'h03;

      // Load A5: shown from the frame after the boundary, two digits enabled
      applyStimulus(32'h0000_00A5, 8'h00, acc1);
      checkOutput("t2_accept", 32'(acc1), 32'd1);
      waitUntil(33);
      checkOutput("t2_an0", 32'(AN), 32'hFE);
      checkOutput("t2_seg0", 32'(seg_out), 32'b0100100);
      waitUntil(37);
      checkOutput("t2_an1", 32'(AN), 32'hFD);
      checkOutput("t2_seg1", 32'(seg_out), 32'b0001000);
      waitUntil(41);
      checkOutput("t2_an2", 32'(AN), 32'hFF);
      checkOutput("t2_seg2", 32'(seg_out), 32'h7F);

      // Second word offered while the first is pending
      applyStimulus(32'h1234_5678, 8'h00, acc1);
      applyStimulus(32'h9ABC_DEF0, 8'h00, acc2);
      checkOutput("t3_phase", 32'(acc2 % 32), 32'd0);
      checkOutput("t3_frame", 32'(acc2 / 32), 32'(acc1 / 32 + 1));

      // Transfer landing on the boundary cycle waits a whole frame
      waitUntil(127);
      load_data = 32'h0000_00C3;
      load_valid = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      checkOutput("t4_phase", 32'((t_model - 1) % 32), 32'd31);
      checkOutput("t4_ready0", 32'(load_ready), 32'd0);
      waitUntil(129);
      checkOutput("t4_oldseg", 32'(seg_out), 32'b0000001);
      waitUntil(159);
      checkOutput("t4_ready_hold", 32'(load_ready), 32'd0);
      waitUntil(160);
      checkOutput("t4_ready_back", 32'(load_ready), 32'd1);
      waitUntil(161);
      checkOutput("t4_newseg", 32'(seg_out), 32'b0000110);

      // Reset during digit 5 with a word pending
      digit_en = 8'hFF;
      applyStimulus(32'h8888_8888, 8'h00, acc1);
      waitUntil(181);
      BTNC = 1'b1;
      @(posedge clk);
      #1;
      BTNC = 1'b0;
      checkOutput("t5_an_blank", 32'(AN), 32'hFF);
      checkOutput("t5_seg_blank", 32'(seg_out), 32'h7F);
      checkOutput("t5_ready", 32'(load_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("t5_an_d0", 32'(AN), 32'hFE);
      checkOutput("t5_seg_d0", 32'(seg_out), 32'b0000001);
      waitUntil(33);
      checkOutput("t5_lost_an", 32'(AN), 32'hFE);
      checkOutput("t5_lost_seg", 32'(seg_out), 32'b0000001);

`ifdef SEG7_DP_EN
      // Decimal point lit only in the digit-0 slot
      applyStimulus(32'h0000_0000, 8'h01, acc1);
      waitUntil(65);
      checkOutput("t6_dp_on", 32'(DP), 32'd0);
      waitUntil(69);
      checkOutput("t6_dp_off", 32'(DP), 32'd1);
`endif

      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
